muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq -- sequential unsigned multiplier / divider
//
// One operation at a time. Multiply is radix-2 shift-add over a 2*WIDTH
// accumulator; divide is restoring division producing one quotient bit per
// cycle. Every accepted operation spends exactly WIDTH cycles in RUN and then
// pulses done for one cycle in DONE.
//
// Optional feature:
//   MULDIV_SEQ_DIV_EN  -- when defined, the divider datapath and the DIVU/REMU
//                         ops are built. When undefined, there is no divider
//                         logic, and op[1]=1 goes straight to DONE with result 0.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request to begin an operation
//   op[1:0]      in   00 MUL (low product), 01 MULHU (high product),
//                     10 DIVU (quotient),   11 REMU (remainder)
//   a, b         in   unsigned operands (b = multiplier / divisor)
//   busy         out  high while in RUN
//   done         out  one-cycle completion pulse (high while in DONE)
//   result       out  result, held from done until the next completion
//   div_by_zero  out  set with result when a DIVU/REMU had b == 0
//   state_dbg    out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a request and "not busy" is the ready. A request is
// accepted on any rising edge where start=1 while the FSM is in IDLE or DONE;
// op, a and b are captured on that same edge. start during RUN is ignored.
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   a_q;
    logic               op_lo_q;

    // Multiply step: add the multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, keeping the carry, then shift right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;

`ifdef MULDIV_SEQ_DIV_EN
    logic [WIDTH-1:0]   b_q;
    logic               is_div_q;

    // Divide step: acc holds {partial remainder, dividend/quotient}. The
    // remainder is shifted left by one dividend bit into a WIDTH+1-bit
    // partial remainder, compared with the divisor, and conditionally
    // reduced. Because the remainder is always below the divisor, the reduced
    // value fits back into WIDTH bits. With b == 0 every compare succeeds,
    // which naturally yields an all-ones quotient and a remainder equal to a.
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_step;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
`ifdef MULDIV_SEQ_DIV_EN
                    state_nxt = S_RUN;
`else
                    state_nxt = op[1] ? S_DONE : S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept = 1'b1;
`ifdef MULDIV_SEQ_DIV_EN
                    state_nxt = S_RUN;
`else
                    state_nxt = op[1] ? S_DONE : S_RUN;
`endif
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign last      = (state == S_RUN) && (cnt == '0);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    // ---------------------------------------------------- datapath (comb)
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_step = {mul_sum, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_SEQ_DIV_EN
    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_shift[WIDTH-1:0] - b_q;
        if (div_ge) begin
            div_step = {div_rem, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    assign acc_nxt = is_div_q ? div_step : mul_step;
`else
    assign acc_nxt = mul_step;
`endif

    // ---------------------------------------------------- datapath (regs)
    // After the last step both ops leave their answers in the same places:
    // low half = MUL product / DIVU quotient, high half = MULHU / REMU.
    // So op[0] alone picks the half to return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            a_q         <= '0;
            op_lo_q     <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
            b_q         <= '0;
            is_div_q    <= 1'b0;
`endif
        end else if (accept) begin
            cnt     <= CNT_INIT;
            a_q     <= a;
            op_lo_q <= op[0];
`ifdef MULDIV_SEQ_DIV_EN
            b_q      <= b;
            is_div_q <= op[1];
            // Multiply shifts the multiplier out of the low half; divide
            // shifts the dividend out of it and the quotient in.
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
`else
            acc      <= {{WIDTH{1'b0}}, b};
            // Without a divider, DIVU/REMU finish on the accepting edge.
            if (op[1]) begin
                result      <= '0;
                div_by_zero <= 1'b0;
            end
`endif
        end else if (state == S_RUN) begin
            acc <= acc_nxt;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (last) begin
                result <= op_lo_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
`ifdef MULDIV_SEQ_DIV_EN
                div_by_zero <= is_div_q && (b_q == '0);
`else
                div_by_zero <= 1'b0;
`endif
            end
        end
    end

endmodule
